alu_arbiter: RTL and testbench

- Shares the single registered ALU between two requesters, e.g. the address-increment path and the execute stage.
- Arbitrates requests, drives the ALU's OP/Operand1/Operand2 inputs, and waits out the ALU's one-clock result register.
- Returns the result, tagged with the requester ID, over a valid/ready response channel.
- Rejects operation codes the ALU does not implement, without using the ALU.

---
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the two-requester ALU arbiter.
// Data buses are N+1 bits, two's complement, matching the shared ALU.
// master : the environment (requesters, ALU, response consumer)
// slave  : the arbiter itself
interface alu_arbiter_if #(
   parameter int N = 3
);
   // request side, bit i / field set i belongs to requester i
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [2:0]        req0_op;
   logic signed [N:0] req0_a;
   logic signed [N:0] req0_b;
   logic [2:0]        req1_op;
   logic signed [N:0] req1_a;
   logic signed [N:0] req1_b;

   // shared registered ALU
   logic [2:0]        alu_op;
   logic signed [N:0] alu_a;
   logic signed [N:0] alu_b;
   logic signed [N:0] alu_out;

   // response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic signed [N:0] rsp_data;
   logic              rsp_err;

   // status
   logic              busy;

   modport master (
      output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
      input  req_ready,
      input  alu_op, alu_a, alu_b,
      output alu_out,
      input  rsp_valid, rsp_id, rsp_data, rsp_err,
      output rsp_ready,
      input  busy
   );

   modport slave (
      input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
      output req_ready,
      output alu_op, alu_a, alu_b,
      input  alu_out,
      output rsp_valid, rsp_id, rsp_data, rsp_err,
      input  rsp_ready,
      output busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters.
// Round-robin arbitration in IDLE, drives the ALU for one cycle (EXEC), samples the
// ALU result register one cycle later (CAPT) and presents it on a valid/ready
// response channel tagged with the requester ID (RESP). Op codes 4..7 are not
// implemented by the ALU and are answered immediately with rsp_err=1.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN -- requester 0 always wins a tie.
module alu_arbiter #(
   parameter int N = 3
) (
   input  logic clock,
   input  logic reset,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic              last_grant_reg, last_grant_next;
   logic              rsp_valid_reg, rsp_valid_next;
   logic              rsp_id_reg, rsp_id_next;
   logic signed [N:0] rsp_data_reg, rsp_data_next;
   logic              rsp_err_reg, rsp_err_next;
   logic [2:0]        alu_op_reg, alu_op_next;
   logic signed [N:0] alu_a_reg, alu_a_next;
   logic signed [N:0] alu_b_reg, alu_b_next;

   // requester fields gathered into arrays so the winner can index them
   logic [2:0]        req_op [2];
   logic signed [N:0] req_a  [2];
   logic signed [N:0] req_b  [2];

   logic              winner;
   logic              accept;
   logic [1:0]        ready_vec;
   logic [2:0]        sel_op;
   logic signed [N:0] sel_a;
   logic signed [N:0] sel_b;
   logic              sel_supported;

   assign req_op[0] = bus.req0_op;
   assign req_a[0]  = bus.req0_a;
   assign req_b[0]  = bus.req0_b;
   assign req_op[1] = bus.req1_op;
   assign req_a[1]  = bus.req1_a;
   assign req_b[1]  = bus.req1_b;

   // Pick the winner: a lone requester wins outright, a tie goes to the one not granted last
   always_comb begin
      winner = bus.req_valid[1];
      if (bus.req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         winner = 1'b0;
`else
         winner = ~last_grant_reg;
`endif
      end
   end

   // a request is only ever taken while idle; the handshake cycle in RESP never accepts
   assign accept = (state_reg == IDLE) && (bus.req_valid != 2'b00);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ready
         localparam logic ID = 1'(gi);
         assign ready_vec[gi] = accept && (winner == ID);
      end
   endgenerate

   assign sel_op        = req_op[winner];
   assign sel_a         = req_a[winner];
   assign sel_b         = req_b[winner];
   assign sel_supported = (sel_op <= 3'd3);

   // Next-state and datapath updates; every register holds unless its state changes it
   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      rsp_valid_next  = rsp_valid_reg;
      rsp_id_next     = rsp_id_reg;
      rsp_data_next   = rsp_data_reg;
      rsp_err_next    = rsp_err_reg;
      alu_op_next     = alu_op_reg;
      alu_a_next      = alu_a_reg;
      alu_b_next      = alu_b_reg;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               last_grant_next = winner;
               rsp_id_next     = winner;
               if (sel_supported) begin
                  alu_op_next = sel_op;
                  alu_a_next  = sel_a;
                  alu_b_next  = sel_b;
                  state_next  = EXEC;
               end else begin
                  // unsupported op: answer at once and leave the ALU inputs alone
                  rsp_err_next   = 1'b1;
                  rsp_data_next  = '0;
                  rsp_valid_next = 1'b1;
                  state_next     = RESP;
               end
            end
         end

         EXEC: begin
            // ALU inputs are held; the ALU registers its result on this edge
            state_next = CAPT;
         end

         CAPT: begin
            // the only state in which alu_out is meaningful
            rsp_data_next  = bus.alu_out;
            rsp_err_next   = 1'b0;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
         end

         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         rsp_valid_reg  <= 1'b0;
         rsp_id_reg     <= 1'b0;
         rsp_data_reg   <= '0;
         rsp_err_reg    <= 1'b0;
         alu_op_reg     <= 3'd0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         rsp_valid_reg  <= rsp_valid_next;
         rsp_id_reg     <= rsp_id_next;
         rsp_data_reg   <= rsp_data_next;
         rsp_err_reg    <= rsp_err_next;
         alu_op_reg     <= alu_op_next;
         alu_a_reg      <= alu_a_next;
         alu_b_reg      <= alu_b_next;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.alu_op    = alu_op_reg;
   assign bus.alu_a     = alu_a_reg;
   assign bus.alu_b     = alu_b_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with an external registered ALU model.
// A transaction-level reference predicts grants, ALU input values, responses and their
// cycle of appearance; a monitor compares the DUT against it every cycle.
module tb_alu_arbiter;
   localparam int N = 3;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   alu_arbiter_if #(.N(N)) bus();

   alu_arbiter #(.N(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // ALU arithmetic on N+1 bit words, no saturation
   function automatic logic [N:0] alu_ref(input logic [2:0] op, input logic [N:0] a, input logic [N:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a >> b;
         3'd2:    return a | b;
         default: return a & b;
      endcase
   endfunction

   // shared ALU: one-clock result register, no reset
   always @(posedge clock) bus.alu_out <= alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

   typedef struct {
      logic       id;
      logic [N:0] data;
      logic       err;
      int         vcyc;
   } exp_t;

   int         cyc = 0;
   exp_t       q[$];
   bit         m_idle = 1'b1;
   logic       m_last = 1'b1;
   int         m_vcyc = 0;
   logic [2:0] sh_op = 3'd0;
   logic [N:0] sh_a = '0;
   logic [N:0] sh_b = '0;
   logic [1:0] exp_ready;
   logic       exp_busy;
   logic [2:0] exp_op;
   logic [N:0] exp_a;
   logic [N:0] exp_b;
   event       model_done;

   int         checks = 0;
   int         errors = 0;
   int         n_rsp = 0;
   bit         prev_reset = 1'b1;
   bit         end_req = 1'b0;
   bit         end_done = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   // Reference model: predicts this cycle's outputs, then advances to the next cycle
   always @(negedge clock) begin
      logic       w;
      logic [2:0] op;
      logic [N:0] a;
      logic [N:0] b;
      exp_t       e;
      w = 1'b0;
      exp_ready = 2'b00;
      if (m_idle && bus.req_valid != 2'b00) begin
         if (bus.req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = ~m_last;
`endif
         end else begin
            w = bus.req_valid[1];
         end
         exp_ready = w ? 2'b10 : 2'b01;
      end
      exp_busy = !m_idle;
      exp_op   = sh_op;
      exp_a    = sh_a;
      exp_b    = sh_b;

      if (reset) begin
         q.delete();
         m_idle = 1'b1;
         m_last = 1'b1;
         sh_op  = 3'd0;
         sh_a   = '0;
         sh_b   = '0;
      end else if (exp_ready != 2'b00) begin
         op   = w ? bus.req1_op : bus.req0_op;
         a    = w ? $unsigned(bus.req1_a) : $unsigned(bus.req0_a);
         b    = w ? $unsigned(bus.req1_b) : $unsigned(bus.req0_b);
         e.id = w;
         if (op < 3'd4) begin
            e.data = alu_ref(op, a, b);
            e.err  = 1'b0;
            e.vcyc = cyc + 3;
            sh_op  = op;
            sh_a   = a;
            sh_b   = b;
         end else begin
            e.data = '0;
            e.err  = 1'b1;
            e.vcyc = cyc + 1;
         end
         q.push_back(e);
         m_last = w;
         m_idle = 1'b0;
         m_vcyc = e.vcyc;
      end else if (!m_idle && cyc >= m_vcyc && bus.rsp_ready) begin
         m_idle = 1'b1;
      end
      -> model_done;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // Monitor: compares DUT outputs with the model and retires responses on handshake
   always begin
      bit exp_v;
      @(model_done);
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("alu_op", 32'(bus.alu_op), 32'(exp_op));
      check("alu_a", 32'($unsigned(bus.alu_a)), 32'(exp_a));
      check("alu_b", 32'($unsigned(bus.alu_b)), 32'(exp_b));
      if (prev_reset && !reset) begin
         check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
         check("rst_rsp_data", 32'($unsigned(bus.rsp_data)), 32'd0);
         check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      end
      if (!reset) begin
         exp_v = (q.size() != 0) && (cyc >= q[0].vcyc);
         check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
         if (bus.rsp_valid && exp_v) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
            check("rsp_data", 32'($unsigned(bus.rsp_data)), 32'(q[0].data));
            check("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
            if (bus.rsp_ready) begin
               n_rsp++;
               $display("RSP %0d cycle %0d id=%0d data=%0h err=%0b", n_rsp, cyc,
                        bus.rsp_id, $unsigned(bus.rsp_data), bus.rsp_err);
               void'(q.pop_front());
            end
         end
      end
      if (end_req && !end_done) begin
         check("drain_outstanding", 32'(q.size()), 32'd0);
         end_done = 1'b1;
      end
      prev_reset = reset;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [N:0] a, input logic [N:0] b);
      if (i == 0) begin
         bus.req0_op = op;
         bus.req0_a  = a;
         bus.req0_b  = b;
      end else begin
         bus.req1_op = op;
         bus.req1_a  = a;
         bus.req1_b  = b;
      end
      bus.req_valid[i] = 1'b1;
   endtask

   // wait (bounded) until requester i is granted, then withdraw its request
   task automatic wait_grant(input int i);
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (bus.req_ready[i]) break;
      end
      tick();
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic send(input int i, input logic [2:0] op, input logic [N:0] a, input logic [N:0] b);
      set_req(i, op, a, b);
      wait_grant(i);
   endtask

   task automatic drain();
      for (int k = 0; k < 80; k++) begin
         @(negedge clock);
         if (m_idle && q.size() == 0) break;
      end
      tick();
   endtask

   // Stimulus: directed scenarios followed by randomized traffic with backpressure
   initial begin
      logic [1:0] g;
      reset         = 1'b1;
      bus.req_valid = 2'b00;
      bus.req0_op   = 3'd0;
      bus.req0_a    = '0;
      bus.req0_b    = '0;
      bus.req1_op   = 3'd0;
      bus.req1_a    = '0;
      bus.req1_b    = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      tick();

      // single add from requester 0
      send(0, 3'd0, 4'd3, 4'd2);
      drain();

      // both requesters continuously valid: alternating grants
      set_req(0, 3'd2, 4'b0101, 4'b1010);
      set_req(1, 3'd3, 4'b0110, 4'b0011);
      repeat (18) tick();
      bus.req_valid = 2'b00;
      drain();

      // wrap-around add and logical shift of a negative value
      send(0, 3'd0, 4'd7, 4'd1);
      drain();
      send(1, 3'd1, 4'b1000, 4'd1);
      drain();

      // unsupported op from requester 1
      send(1, 3'd5, 4'd3, 4'd4);
      drain();

      // backpressure in RESP with requester 0 waiting
      bus.rsp_ready = 1'b0;
      send(0, 3'd3, 4'hC, 4'hA);
      set_req(0, 3'd0, 4'd1, 4'd2);
      repeat (8) tick();
      bus.rsp_ready = 1'b1;
      wait_grant(0);
      drain();

      // reset while the result is being captured
      send(0, 3'd0, 4'd1, 4'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_req(0, 3'd2, 4'd1, 4'd2);
      set_req(1, 3'd0, 4'd5, 4'd6);
      repeat (10) tick();
      bus.req_valid = 2'b00;
      drain();

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         @(negedge clock);
         g = bus.req_ready;
         tick();
         for (int i = 0; i < 2; i++) begin
            if (g[i] || !bus.req_valid[i]) begin
               if ($urandom_range(0, 2) != 0)
                  set_req(i, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
               else
                  bus.req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
               bus.req_valid[i] = 1'b0;
            end
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b1;
      drain();

      end_req = 1'b1;
      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
